// File: rtl/pulse_event_queue_pkg.sv
// Shared types and defaults for the pulse event queue.
// Optional timestamping is enabled by defining PULSE_EVT_TSTAMP_EN.
package pulse_evt_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } evt_state_e;

  localparam int unsigned DEF_DEPTH = 8;
  localparam int unsigned DEF_TS_W  = 16;

  // Pointer width that stays legal for a single-entry queue.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pulse_event_queue_if.sv
// Event handshake bundle between the pulse event queue and its environment.
// evt_tstamp exists only when PULSE_EVT_TSTAMP_EN is defined.
interface pulse_event_queue_if
  import pulse_evt_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned TS_W  = DEF_TS_W
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  if (DEPTH < 1 || TS_W < 1) begin : g_param_check
    $error("pulse_event_queue_if: DEPTH and TS_W must be >= 1");
  end

  logic             sync_pulse;
  logic             evt_valid;
  logic             evt_ready;
  logic [CNT_W-1:0] evt_pending;
  logic             ovf;
  logic             ovf_clr;
`ifdef PULSE_EVT_TSTAMP_EN
  logic [TS_W-1:0]  evt_tstamp;
`endif

  // Queue side
  modport slave (
    input  sync_pulse,
    input  evt_ready,
    input  ovf_clr,
    output evt_valid,
    output evt_pending,
    output ovf
`ifdef PULSE_EVT_TSTAMP_EN
    , output evt_tstamp
`endif
  );

  // Producer / consumer side
  modport master (
    output sync_pulse,
    output evt_ready,
    output ovf_clr,
    input  evt_valid,
    input  evt_pending,
    input  ovf
`ifdef PULSE_EVT_TSTAMP_EN
    , input  evt_tstamp
`endif
  );

endinterface

// File: rtl/pulse_event_queue_tstamp_fifo.sv
// DEPTH x TS_W timestamp FIFO; occupancy comes from the parent's pending count.
// Only instantiated when PULSE_EVT_TSTAMP_EN is defined.
module tstamp_fifo
  import pulse_evt_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned TS_W  = DEF_TS_W,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [TS_W-1:0]  i_data,
  input  logic [CNT_W-1:0] i_pending,
  output logic [TS_W-1:0]  o_head
);
  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [TS_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             w_empty;
  logic             w_full;
  logic             w_wr_en;
  logic             w_rd_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign w_empty = (i_pending == '0);
  assign w_full  = (i_pending == CNT_W'(DEPTH));
  assign w_rd_en = i_pop & ~w_empty;
  // At full a write is only legal when the head leaves in the same cycle.
  assign w_wr_en = i_push & (~w_full | w_rd_en);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_rd_en) r_rd_ptr <= ptr_inc(r_rd_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head = w_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/pulse_event_queue.sv
// Turns synchronized one-cycle pulses into a counted valid/ready event stream.
// Define PULSE_EVT_TSTAMP_EN to attach a per-event timestamp FIFO.
module pulse_event_queue
  import pulse_evt_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned TS_W  = DEF_TS_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pulse_event_queue_if.slave   evt_if
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  if (DEPTH < 1 || TS_W < 1) begin : g_param_check
    $error("pulse_event_queue: DEPTH and TS_W must be >= 1");
  end

  evt_state_e       r_state;
  evt_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_pending;
  logic             r_ovf;
  logic             w_valid;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_accept;
  logic             w_drop;

  assign w_push   = evt_if.sync_pulse;
  assign w_pop    = w_valid & evt_if.evt_ready;
  assign w_full   = (r_pending == FULL_CNT);
  // A pop frees the slot the same cycle, so push at full is still accepted.
  assign w_accept = w_push & (~w_full | w_pop);
  assign w_drop   = w_push & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_push) w_state_nxt = ACTIVE;
      ACTIVE:  if ((r_pending == CNT_W'(1)) && w_pop && !w_push) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_valid = (r_state == ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else if (w_accept && !w_pop) begin
      r_pending <= r_pending + CNT_W'(1);
    end else if (!w_accept && w_pop) begin
      r_pending <= r_pending - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                r_ovf <= 1'b0;
    else if (w_drop)           r_ovf <= 1'b1;
    else if (evt_if.ovf_clr)   r_ovf <= 1'b0;
  end

  assign evt_if.evt_valid   = w_valid;
  assign evt_if.evt_pending = r_pending;
  assign evt_if.ovf         = r_ovf;

`ifdef PULSE_EVT_TSTAMP_EN
  logic [TS_W-1:0] r_ts;
  logic [TS_W-1:0] w_head;

  always_ff @(posedge clk) begin
    if (!rst_n) r_ts <= '0;
    else        r_ts <= r_ts + TS_W'(1);
  end

  tstamp_fifo #(
    .DEPTH (DEPTH),
    .TS_W  (TS_W),
    .CNT_W (CNT_W)
  ) u_tstamp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_accept),
    .i_pop     (w_pop),
    .i_data    (r_ts),
    .i_pending (r_pending),
    .o_head    (w_head)
  );

  assign evt_if.evt_tstamp = w_head;
`endif

endmodule
